prf_release_buffer: RTL and testbench
=====================================

Name: prf_release_buffer

Overview:
- Write-side producer for the 2-in/2-out physical register freelist.
- Collects up to two retired old-destination physical register numbers per cycle from the commit stage and holds them in a small circular buffer.
- Drains the buffer into the freelist's wr_first/wr_second ports, obeying the freelist's full/almost_full backpressure.
- Compacts sparse release slots so the freelist always receives writes on the first port first.

Parameters:
PREG_WIDTH, 5, width of a physical register number (matches freelist FIFO_DATA_WIDTH)
BUF_SIZE, 8, buffer entries; power of two, >= 4
BUF_SIZE_WIDTH, 3, log2(BUF_SIZE)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rel_first_vld_i  input  1  commit slot 0 releases a register
rel_first_preg_i  input  PREG_WIDTH  slot 0 register number
rel_second_vld_i  input  1  commit slot 1 releases a register
rel_second_preg_i  input  PREG_WIDTH  slot 1 register number
rel_ready_o  output  1  buffer can accept two releases this cycle
fifo_full_i  input  1  freelist full
fifo_almost_full_i  input  1  freelist has at most one free slot
wr_first_en_o  output  1  freelist write port 0 enable
wdata_first_o  output  PREG_WIDTH  freelist write port 0 data
wr_second_en_o  output  1  freelist write port 1 enable
wdata_second_o  output  PREG_WIDTH  freelist write port 1 data
buf_num_o  output  BUF_SIZE_WIDTH+1  current entry count
buf_empty_o  output  1  count == 0

Behaviour:
- State: entry array, head pointer, tail pointer (BUF_SIZE_WIDTH bits, wrap mod BUF_SIZE), count (BUF_SIZE_WIDTH+1 bits). All update on posedge clk.
- Reset (rst=1 at posedge): head=tail=count=0. Resulting outputs: wr_first_en_o=0, wr_second_en_o=0, buf_num_o=0, buf_empty_o=1, rel_ready_o=1. Reset overrides any same-cycle enqueue or dequeue; buffered entries are discarded. Entry array contents need not be reset.
- Accept filter: slot k is effective when rel_k_vld_i=1, rel_k_preg_i!=0 (p0 is never freed) and rel_ready_o=1. If rel_ready_o=0, the inputs are ignored; driving a valid then is a protocol error and is flagged by a bench assertion.
- Enqueue:
  - Two effective slots: first -> entry[tail], second -> entry[tail+1], tail += 2.
  - One effective slot (either position): that value -> entry[tail], tail += 1.
  - Zero effective slots: no change.
- rel_ready_o = (BUF_SIZE - count) >= 2. Combinational from registered count only; it does not depend on the current cycle's dequeue.
- Drain (combinational from registered state):
  - wdata_first_o = entry[head]; wdata_second_o = entry[head+1].
  - wr_first_en_o = (count >= 1) & !fifo_full_i.
  - wr_second_en_o = (count >= 2) & !fifo_full_i & !fifo_almost_full_i.
  - head advances by wr_first_en_o + wr_second_en_o.
  - wr_second_en_o=1 implies wr_first_en_o=1.
- Latency: a release accepted at edge N is visible on the write ports in cycle N+1 (no bypass when empty).
- Count update: count_next = count + enq_num - deq_num, where enq_num and deq_num are each 0..2. Simultaneous enqueue and dequeue in one cycle is legal, including at count=BUF_SIZE-2 and at count=1.
- Wrap-around: pointer+1 and pointer+2 wrap modulo BUF_SIZE; two-entry writes and reads straddle the wrap correctly.
- Freelist full: no writes and no head movement; buffer fills until rel_ready_o drops at count >= BUF_SIZE-1.

Test Plan:
- Reset, then single release preg 7 on slot 0 -> cycle+1: wr_first_en_o=1, wdata_first_o=7, wr_second_en_o=0; next cycle buf_empty_o=1.
- Slot 0 invalid, slot 1 preg 9 -> compacted: wr_first_en_o=1, wdata_first_o=9, wr_second_en_o=0.
- Both slots preg 0 and preg 12 -> only 12 accepted; buf_num_o=1.
- fifo_full_i=1 held; issue pairs (1,2),(3,4),(5,6) -> buf_num_o=6 and rel_ready_o=1; after a 4th pair (7,8) buf_num_o=8, rel_ready_o=0. Release full -> pairs (1,2),(3,4),(5,6),(7,8) written in order on the two ports.
- fifo_almost_full_i=1, fifo_full_i=0, count=3 -> only port 0 writes per cycle; values emerge in FIFO order.
- Continuous pairs with no backpressure for 20 cycles (crosses wrap at 8) -> buf_num_o stays <=2, output sequence equals input sequence; assert rst mid-stream -> next cycle buf_num_o=0, no write enables.

Source files
------------

// File: rtl/prf_release_buffer.sv
// prf_release_buffer
// Collects up to two retired physical register numbers per cycle from commit,
// holds them in a small circular buffer, and drains them into the 2-in
// physical register freelist while respecting its full/almost_full signals.
// Sparse release slots are compacted so the freelist always sees port 0 first.

module prf_release_buffer #(
  parameter int PREG_WIDTH     = 5,
  parameter int BUF_SIZE       = 8,
  parameter int BUF_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rel_first_vld_i,
  input  logic [PREG_WIDTH-1:0]     rel_first_preg_i,
  input  logic                      rel_second_vld_i,
  input  logic [PREG_WIDTH-1:0]     rel_second_preg_i,
  output logic                      rel_ready_o,
  input  logic                      fifo_full_i,
  input  logic                      fifo_almost_full_i,
  output logic                      wr_first_en_o,
  output logic [PREG_WIDTH-1:0]     wdata_first_o,
  output logic                      wr_second_en_o,
  output logic [PREG_WIDTH-1:0]     wdata_second_o,
  output logic [BUF_SIZE_WIDTH:0]   buf_num_o,
  output logic                      buf_empty_o
);

  localparam logic [BUF_SIZE_WIDTH:0] READY_MAX_CNT = (BUF_SIZE_WIDTH+1)'(BUF_SIZE - 2);

  logic [PREG_WIDTH-1:0]     entries [BUF_SIZE];
  logic [BUF_SIZE_WIDTH-1:0] head;
  logic [BUF_SIZE_WIDTH-1:0] tail;
  logic [BUF_SIZE_WIDTH:0]   count;

  logic [BUF_SIZE_WIDTH-1:0] head_p1;
  logic [BUF_SIZE_WIDTH-1:0] tail_p1;
  logic                      first_eff;
  logic                      second_eff;
  logic [1:0]                enq_num;
  logic [1:0]                deq_num;
  logic [PREG_WIDTH-1:0]     enq_data0;
  logic [BUF_SIZE_WIDTH:0]   count_next;

  // BUF_SIZE is a power of two, so plain pointer arithmetic wraps for free.
  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  // Ready looks only at the registered count, never at this cycle's drain,
  // so there is no combinational path from the freelist back to commit.
  assign rel_ready_o = (count <= READY_MAX_CNT);

  // Drain side: everything is driven from registered state plus backpressure.
  assign wr_first_en_o  = (count != '0) && !fifo_full_i;
  assign wr_second_en_o = (count >= (BUF_SIZE_WIDTH+1)'(2)) && !fifo_full_i && !fifo_almost_full_i;
  assign wdata_first_o  = entries[head];
  assign wdata_second_o = entries[head_p1];
  assign buf_num_o      = count;
  assign buf_empty_o    = (count == '0);

  // Accept filter, compaction and count arithmetic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    first_eff  = 1'b0;
    second_eff = 1'b0;
    enq_data0  = rel_second_preg_i;
    first_eff  = rel_first_vld_i  && (rel_first_preg_i  != '0) && rel_ready_o;
    second_eff = rel_second_vld_i && (rel_second_preg_i != '0) && rel_ready_o;
    // A lone slot-1 release moves down to the tail entry.
    if (first_eff) enq_data0 = rel_first_preg_i;
    enq_num    = {1'b0, first_eff} + {1'b0, second_eff};
    deq_num    = {1'b0, wr_first_en_o} + {1'b0, wr_second_en_o};
    count_next = count + (BUF_SIZE_WIDTH+1)'(enq_num) - (BUF_SIZE_WIDTH+1)'(deq_num);
  end

  // Entry storage: written at tail, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; count gates every read, so stale contents are never observed and the array can map to plain storage.
    if (first_eff || second_eff) entries[tail] <= enq_data0;
    if (first_eff && second_eff) entries[tail_p1] <= rel_second_preg_i;
  end

  // Pointer and count state with synchronous reset overriding enqueue/dequeue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + BUF_SIZE_WIDTH'(deq_num);
      tail  <= tail + BUF_SIZE_WIDTH'(enq_num);
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_prf_release_buffer.sv
// Directed bench for prf_release_buffer: a table of per-cycle vectors with
// hand-computed outputs, plus a streaming sequence across the pointer wrap
// and a mid-stream reset.

module tb_prf_release_buffer;

  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1;
  logic [PW-1:0] p0, p1;
  logic          full, af;
  logic          rdy, we0, we1, empty;
  logic [PW-1:0] wd0, wd1;
  logic [3:0]    num;

  int n_checks = 0;
  int n_fail   = 0;

  prf_release_buffer #(.PREG_WIDTH(5), .BUF_SIZE(8), .BUF_SIZE_WIDTH(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .rel_first_vld_i    (v0),
    .rel_first_preg_i   (p0),
    .rel_second_vld_i   (v1),
    .rel_second_preg_i  (p1),
    .rel_ready_o        (rdy),
    .fifo_full_i        (full),
    .fifo_almost_full_i (af),
    .wr_first_en_o      (we0),
    .wdata_first_o      (wd0),
    .wr_second_en_o     (we1),
    .wdata_second_o     (wd1),
    .buf_num_o          (num),
    .buf_empty_o        (empty)
  );

  always #5 clk = ~clk;

  // Driving a release while the buffer is not ready is a protocol error.
  always @(posedge clk) begin
    assert (rst || rdy || !(v0 || v1))
      else $error("release driven while rel_ready_o is low");
  end

  typedef struct {
    logic          v0;
    logic [PW-1:0] p0;
    logic          v1;
    logic [PW-1:0] p1;
    logic          full;
    logic          af;
    logic          we0;
    logic [PW-1:0] wd0;
    logic          we1;
    logic [PW-1:0] wd1;
    int            num;
    logic          rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic a_v0, int a_p0, logic a_v1, int a_p1,
                              logic a_full, logic a_af,
                              logic e_we0, int e_wd0, logic e_we1, int e_wd1,
                              int e_num, logic e_rdy);
    vec_t v;
    v.v0 = a_v0;   v.p0 = PW'(a_p0);
    v.v1 = a_v1;   v.p1 = PW'(a_p1);
    v.full = a_full; v.af = a_af;
    v.we0 = e_we0; v.wd0 = PW'(e_wd0);
    v.we1 = e_we1; v.wd1 = PW'(e_wd1);
    v.num = e_num; v.rdy = e_rdy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    v0 = 1'b0; p0 = '0; v1 = 1'b0; p1 = '0;
  endtask

  initial begin
    logic [PW-1:0] q[$];
    logic [PW-1:0] a, b;
    int exp_deq;

    rst = 1'b1; full = 1'b0; af = 1'b0;
    drive_idle();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset we0",   32'(we0),   0);
    check("reset we1",   32'(we1),   0);
    check("reset num",   32'(num),   0);
    check("reset empty", 32'(empty), 1);
    check("reset rdy",   32'(rdy),   1);
    rst = 1'b0;

    // Each row: inputs driven this cycle, outputs expected this cycle (before the edge).
    //                   v0 p0  v1 p1  full af  we0 wd0 we1 wd1 num rdy
    // single release of 7 on slot 0
    vecs.push_back(mk(1,  7, 0,  0,  0, 0,  0,  0, 0,  0,  0, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1,  7, 0,  0,  1, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  0,  0, 0,  0,  0, 1));
    // slot 1 only: compacted onto port 0
    vecs.push_back(mk(0,  0, 1,  9,  0, 0,  0,  0, 0,  0,  0, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1,  9, 0,  0,  1, 1));
    // p0 is filtered, only 12 is kept
    vecs.push_back(mk(1,  0, 1, 12,  0, 0,  0,  0, 0,  0,  0, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1, 12, 0,  0,  1, 1));
    // freelist full: fill the buffer with four pairs
    vecs.push_back(mk(1,  1, 1,  2,  1, 0,  0,  0, 0,  0,  0, 1));
    vecs.push_back(mk(1,  3, 1,  4,  1, 0,  0,  0, 0,  0,  2, 1));
    vecs.push_back(mk(1,  5, 1,  6,  1, 0,  0,  0, 0,  0,  4, 1));
    vecs.push_back(mk(1,  7, 1,  8,  1, 0,  0,  0, 0,  0,  6, 1));
    vecs.push_back(mk(0,  0, 0,  0,  1, 0,  0,  0, 0,  0,  8, 0));
    vecs.push_back(mk(0,  0, 0,  0,  1, 0,  0,  0, 0,  0,  8, 0));
    // release full: pairs emerge in order, straddling the wrap
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1,  1, 1,  2,  8, 0));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1,  3, 1,  4,  6, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1,  5, 1,  6,  4, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1,  7, 1,  8,  2, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  0,  0, 0,  0,  0, 1));
    // load three entries, then drain under almost_full: one per cycle
    vecs.push_back(mk(1, 10, 1, 11,  1, 0,  0,  0, 0,  0,  0, 1));
    vecs.push_back(mk(1, 13, 0,  0,  1, 0,  0,  0, 0,  0,  2, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 1,  1, 10, 0,  0,  3, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 1,  1, 11, 0,  0,  2, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 1,  1, 13, 0,  0,  1, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 1,  0,  0, 0,  0,  0, 1));
    // simultaneous enqueue and dequeue at count = BUF_SIZE-2
    vecs.push_back(mk(1, 20, 1, 21,  1, 0,  0,  0, 0,  0,  0, 1));
    vecs.push_back(mk(1, 22, 1, 23,  1, 0,  0,  0, 0,  0,  2, 1));
    vecs.push_back(mk(1, 24, 1, 25,  1, 0,  0,  0, 0,  0,  4, 1));
    vecs.push_back(mk(1, 26, 1, 27,  0, 0,  1, 20, 1, 21,  6, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1, 22, 1, 23,  6, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1, 24, 1, 25,  4, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  1, 26, 1, 27,  2, 1));
    vecs.push_back(mk(0,  0, 0,  0,  0, 0,  0,  0, 0,  0,  0, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      v0 = vecs[i].v0; p0 = vecs[i].p0;
      v1 = vecs[i].v1; p1 = vecs[i].p1;
      full = vecs[i].full; af = vecs[i].af;
      #1;
      check($sformatf("vec%0d we0", i),   32'(we0),   32'(vecs[i].we0));
      check($sformatf("vec%0d we1", i),   32'(we1),   32'(vecs[i].we1));
      check($sformatf("vec%0d num", i),   32'(num),   32'(vecs[i].num));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].num == 0));
      check($sformatf("vec%0d rdy", i),   32'(rdy),   32'(vecs[i].rdy));
      if (vecs[i].we0) check($sformatf("vec%0d wd0", i), 32'(wd0), 32'(vecs[i].wd0));
      if (vecs[i].we1) check($sformatf("vec%0d wd1", i), 32'(wd1), 32'(vecs[i].wd1));
    end

    // Continuous pairs with no backpressure; output order must match input order.
    full = 1'b0; af = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = PW'((2 * i) % 31 + 1);
      b = PW'((2 * i + 1) % 31 + 1);
      v0 = 1'b1; p0 = a; v1 = 1'b1; p1 = b;
      #1;
      check($sformatf("stream%0d num", i), 32'(num), 32'(q.size()));
      check($sformatf("stream%0d num_le2", i), 32'(num <= 4'd2), 1);
      check($sformatf("stream%0d we0", i), 32'(we0), 32'(q.size() >= 1));
      check($sformatf("stream%0d we1", i), 32'(we1), 32'(q.size() >= 2));
      exp_deq = (q.size() >= 2) ? 2 : q.size();
      if (exp_deq >= 1) check($sformatf("stream%0d wd0", i), 32'(wd0), 32'(q[0]));
      if (exp_deq >= 2) check($sformatf("stream%0d wd1", i), 32'(wd1), 32'(q[1]));
      for (int k = 0; k < exp_deq; k++) void'(q.pop_front());
      q.push_back(a);
      q.push_back(b);
    end

    // Reset mid-stream overrides the same-cycle enqueue and dequeue.
    @(negedge clk);
    rst = 1'b1;
    v0 = 1'b1; p0 = 5'd30; v1 = 1'b1; p1 = 5'd31;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    check("midrst num",   32'(num),   0);
    check("midrst empty", 32'(empty), 1);
    check("midrst we0",   32'(we0),   0);
    check("midrst we1",   32'(we1),   0);
    check("midrst rdy",   32'(rdy),   1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
